// File: rtl/avr_intc.sv
// avr_intc: 8-source interrupt controller for the AVR core (synchronize, edge-detect, mask, prioritise, handshake).
// Optional periodic timer on source 7 is enabled by defining AVR_INTC_TIMER_EN.

module avr_intc_src (
    input  logic clock,
    input  logic reset_n,
    input  logic irq_i,
    input  logic tmr_edge_i,
    input  logic ack_clr_i,
    input  logic sw_clr_i,
    output logic pend_o
);
    logic s1_q, s2_q, p_q, pend_q;
    logic edge_w, pend_d;

    // A new edge always wins over either clear so it is never lost.
    assign edge_w = (s2_q & ~p_q) | tmr_edge_i;
    assign pend_d = edge_w | (pend_q & ~ack_clr_i & ~sw_clr_i);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            p_q    <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            s1_q   <= irq_i;
            s2_q   <= s1_q;
            p_q    <= s2_q;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
endmodule

module avr_intc #(
    parameter logic [15:0] BASE = 16'h1800,
    parameter int          NSRC = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  irq,
    input  logic [15:0] address,
    input  logic [7:0]  data_w,
    input  logic        we,
    output logic [7:0]  data_r,
    output logic        sel,
    input  logic        ack,
    output logic        intr,
    output logic [2:0]  vect
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t            state_q;
    logic              intr_q;
    logic [2:0]        vect_q;
    logic [NSRC-1:0]   mask_q;
    logic [NSRC-1:0]   pend;
    logic [NSRC-1:0]   masked;
    logic [NSRC-1:0]   ack_clr;
    logic [NSRC-1:0]   sw_clr;
    logic [NSRC-1:0]   tmr_edge;
    logic [15:0]       offset;
    logic              wr_en;
    logic [2:0]        win;
    logic [7:0]        rd_d;
    logic [7:0]        tmr_rd;

    assign offset = address - BASE;
    assign sel    = (offset[15:2] == 14'd0);
    assign wr_en  = we & sel;
    assign masked = pend & mask_q;

    genvar n;
    generate
        for (n = 0; n < NSRC; n++) begin : g_src
            assign ack_clr[n] = (state_q == S_REQ) & ack & (vect_q == 3'(n));
            assign sw_clr[n]  = wr_en & (offset[1:0] == 2'd1) & data_w[n];
            avr_intc_src u_src (
                .clock      (clock),
                .reset_n    (reset_n),
                .irq_i      (irq[n]),
                .tmr_edge_i (tmr_edge[n]),
                .ack_clr_i  (ack_clr[n]),
                .sw_clr_i   (sw_clr[n]),
                .pend_o     (pend[n])
            );
        end
    endgenerate

    // Lowest-numbered enabled pending source wins.
    always_comb begin
        win = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (masked[i]) win = 3'(i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if (wr_en && offset[1:0] == 2'd0) begin
            mask_q <= data_w;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            intr_q  <= 1'b0;
            vect_q  <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|masked) begin
                        vect_q  <= win;
                        intr_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Ack beats a simultaneous withdrawal; vect is never re-arbitrated here.
                    if (ack) begin
                        intr_q  <= 1'b0;
                        state_q <= S_GAP;
                    end else if (!(pend[vect_q] & mask_q[vect_q])) begin
                        intr_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    intr_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AVR_INTC_TIMER_EN
    logic [7:0]  tmr_q;
    logic [7:0]  tick_q;
    logic [15:0] presc_q;
    logic        tpulse_q;

    // Prescaler wraps every 256 clocks; tick counter divides that by TIMER.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q    <= 8'd0;
            tick_q   <= 8'd0;
            presc_q  <= 16'd0;
            tpulse_q <= 1'b0;
        end else if (wr_en && offset[1:0] == 2'd3) begin
            tmr_q    <= data_w;
            tick_q   <= data_w;
            presc_q  <= 16'd0;
            tpulse_q <= 1'b0;
        end else if (tmr_q != 8'd0) begin
            tpulse_q <= 1'b0;
            if (presc_q == 16'd255) begin
                presc_q <= 16'd0;
                if (tick_q <= 8'd1) begin
                    tick_q   <= tmr_q;
                    tpulse_q <= 1'b1;
                end else begin
                    tick_q <= tick_q - 8'd1;
                end
            end else begin
                presc_q <= presc_q + 16'd1;
            end
        end else begin
            presc_q  <= 16'd0;
            tpulse_q <= 1'b0;
        end
    end

    assign tmr_edge = {tpulse_q, {(NSRC-1){1'b0}}};
    assign tmr_rd   = tmr_q;
`else
    assign tmr_edge = '0;
    assign tmr_rd   = 8'h00;
`endif

    always_comb begin
        rd_d = 8'h00;
        case (offset[1:0])
            2'd0:    rd_d = mask_q;
            2'd1:    rd_d = pend;
            2'd2:    rd_d = {intr_q, 4'b0000, vect_q};
            default: rd_d = tmr_rd;
        endcase
    end

    assign data_r = sel ? rd_d : 8'h00;
    assign intr   = intr_q;
    assign vect   = vect_q;
endmodule

// File: tb/tb_avr_intc.sv
// Self-checking bench for avr_intc: directed scenarios plus random traffic against a cycle-level reference model.
module tb_avr_intc;
    localparam logic [15:0] BASE = 16'h1800;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  irq = 8'h00;
    logic [15:0] address = BASE;
    logic [7:0]  data_w = 8'h00;
    logic        we = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  data_r;
    logic        sel;
    logic        intr;
    logic [2:0]  vect;

    int errors = 0;
    int checks = 0;

    avr_intc #(.BASE(BASE), .NSRC(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .irq     (irq),
        .address (address),
        .data_w  (data_w),
        .we      (we),
        .data_r  (data_r),
        .sel     (sel),
        .ack     (ack),
        .intr    (intr),
        .vect    (vect)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference model: pending set, mask, request mode (0 idle, 1 requesting, 2 gap), irq history.
    bit         model_on = 1'b0;
    logic [7:0] m_mask, m_pend, m_tmr;
    int         m_mode, m_vect;
    logic [7:0] h1, h2, h3;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mask = 0; m_pend = 0; m_tmr = 0;
        m_mode = 0; m_vect = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        int off;
        off = int'(a) - int'(BASE);
        case (off)
            0: return m_mask;
            1: return m_pend;
            2: return {(m_mode == 1) ? 1'b1 : 1'b0, 4'b0000, 3'(m_vect)};
            3: return m_tmr;
            default: return 8'h00;
        endcase
    endfunction

    // One clock edge worth of spec behaviour, using the inputs currently driven.
    task automatic model_edge();
        int off;
        logic [7:0] edges, swclr, ackclr, enabled;
        off     = int'(address) - int'(BASE);
        edges   = h2 & ~h3;
        swclr   = (we && off == 1) ? data_w : 8'h00;
        ackclr  = (m_mode == 1 && ack) ? 8'(1 << m_vect) : 8'h00;
        enabled = m_pend & m_mask;
        if (m_mode == 0) begin
            if (enabled != 0) begin
                for (int i = 7; i >= 0; i--) if (enabled[i]) m_vect = i;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (ack) m_mode = 2;
            else if (!(m_pend[m_vect] && m_mask[m_vect])) m_mode = 0;
        end else begin
            m_mode = 0;
        end
        if (we && off == 0) m_mask = data_w;
`ifdef AVR_INTC_TIMER_EN
        if (we && off == 3) m_tmr = data_w;
`endif
        m_pend = (m_pend & ~swclr & ~ackclr) | edges;
        h3 = h2; h2 = h1; h1 = irq;
    endtask

    task automatic tick();
        if (model_on) model_edge();
        @(posedge clock);
        #1;
        if (model_on) begin
            chk("m_intr", {15'd0, intr}, (m_mode == 1) ? 16'd1 : 16'd0);
            if (m_mode == 1) chk("m_vect", {13'd0, vect}, 16'(m_vect));
            chk("m_sel", {15'd0, sel}, (int'(address) - int'(BASE) >= 0 && int'(address) - int'(BASE) < 4) ? 16'd1 : 16'd0);
            chk("m_data_r", {8'd0, data_r}, {8'd0, model_read(address)});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] val);
        address = BASE + 16'(off);
        data_w  = val;
        we      = 1'b1;
        tick();
        we      = 1'b0;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] off, input logic [7:0] exp);
        address = BASE + 16'(off);
        #1;
        chk(tag, {8'd0, data_r}, {8'd0, exp});
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_intr", {15'd0, intr}, 16'd0);
        chk("rst_vect", {13'd0, vect}, 16'd0);
        expect_reg("rst_mask", 2'd0, 8'h00);
        expect_reg("rst_pend", 2'd1, 8'h00);
        expect_reg("rst_status", 2'd2, 8'h00);
        expect_reg("rst_timer", 2'd3, 8'h00);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        model_on = 1'b1;

        // Single source latency and ack.
        wr(2'd0, 8'h04);
        irq[2] = 1'b1;
        address = BASE + 16'd1;
        ticks(2);
        chk("t1_pend_k1", {8'd0, data_r}, 16'h00);
        tick();
        chk("t1_pend_k2", {8'd0, data_r}, 16'h04);
        chk("t1_intr_k2", {15'd0, intr}, 16'd0);
        tick();
        chk("t1_intr_k3", {15'd0, intr}, 16'd1);
        chk("t1_vect_k3", {13'd0, vect}, 16'd2);
        ack_pulse();
        chk("t1_intr_ack", {15'd0, intr}, 16'd0);
        chk("t1_pend_ack", {8'd0, data_r}, 16'h00);
        irq = 8'h00;
        ticks(3);

        // Simultaneous sources: lowest wins, second follows 2 cycles after ack.
        wr(2'd0, 8'hFF);
        irq = 8'h22;
        ticks(4);
        chk("t2_vect1", {13'd0, vect}, 16'd1);
        chk("t2_intr1", {15'd0, intr}, 16'd1);
        ack_pulse();
        chk("t2_gap", {15'd0, intr}, 16'd0);
        tick();
        chk("t2_idle", {15'd0, intr}, 16'd0);
        tick();
        chk("t2_intr5", {15'd0, intr}, 16'd1);
        chk("t2_vect5", {13'd0, vect}, 16'd5);
        ack_pulse();
        irq = 8'h00;
        ticks(3);

        // Masked capture, then unmask.
        wr(2'd0, 8'h00);
        irq[3] = 1'b1;
        ticks(5);
        chk("t3_intr_masked", {15'd0, intr}, 16'd0);
        expect_reg("t3_pend", 2'd1, 8'h08);
        wr(2'd0, 8'h08);
        chk("t3_intr_w", {15'd0, intr}, 16'd0);
        tick();
        chk("t3_intr", {15'd0, intr}, 16'd1);
        chk("t3_vect", {13'd0, vect}, 16'd3);
        ack_pulse();
        irq = 8'h00;
        ticks(3);

        // Software clear withdraws the request; a late ack is ignored.
        wr(2'd0, 8'h10);
        irq[4] = 1'b1;
        ticks(4);
        chk("t4_intr", {15'd0, intr}, 16'd1);
        chk("t4_vect", {13'd0, vect}, 16'd4);
        wr(2'd1, 8'h10);
        tick();
        chk("t4_withdrawn", {15'd0, intr}, 16'd0);
        expect_reg("t4_status", 2'd2, 8'h04);
        ticks(2);
        ack_pulse();
        expect_reg("t4_pend_after_ack", 2'd1, 8'h00);
        chk("t4_intr_after_ack", {15'd0, intr}, 16'd0);
        irq = 8'h00;
        ticks(3);

        // New edge coincides with its own ack: stays pending and re-requests.
        wr(2'd0, 8'h40);
        irq[6] = 1'b1;
        ticks(4);
        chk("t5_vect", {13'd0, vect}, 16'd6);
        irq[6] = 1'b0;
        tick();
        irq[6] = 1'b1;
        ticks(2);
        ack_pulse();
        chk("t5_intr_gap", {15'd0, intr}, 16'd0);
        expect_reg("t5_pend", 2'd1, 8'h40);
        ticks(2);
        chk("t5_reassert", {15'd0, intr}, 16'd1);
        chk("t5_revect", {13'd0, vect}, 16'd6);
        ack_pulse();
        irq = 8'h00;
        ticks(3);

        // Asynchronous reset in the middle of a request.
        wr(2'd0, 8'h01);
        irq[0] = 1'b1;
        ticks(4);
        chk("t6_intr", {15'd0, intr}, 16'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        irq = 8'h00;
        #1;
        chk("t6_rst_intr", {15'd0, intr}, 16'd0);
        expect_reg("t6_rst_mask", 2'd0, 8'h00);
        expect_reg("t6_rst_pend", 2'd1, 8'h00);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

`ifdef AVR_INTC_TIMER_EN
        begin
            int rises[$];
            int cyc;
            logic prev;
            model_on = 1'b0;
            wr(2'd0, 8'h80);
            wr(2'd3, 8'd2);
            cyc = 0;
            prev = 1'b0;
            while (rises.size() < 3 && cyc < 2500) begin
                tick();
                cyc++;
                ack = 1'b0;
                if (intr && !prev) begin
                    rises.push_back(cyc);
                    ack = 1'b1;
                end
                prev = intr;
            end
            ack = 1'b0;
            chk("tm_rises", 16'(rises.size()), 16'd3);
            if (rises.size() == 3) begin
                chk("tm_period1", (rises[1] - rises[0] >= 509 && rises[1] - rises[0] <= 515) ? 16'd1 : 16'd0, 16'd1);
                chk("tm_period2", (rises[2] - rises[1] >= 509 && rises[2] - rises[1] <= 515) ? 16'd1 : 16'd0, 16'd1);
            end
            cyc = 0;
            while (!intr && cyc < 600) begin
                tick();
                cyc++;
            end
            chk("tm_req", {15'd0, intr}, 16'd1);
            #2;
            reset_n = 1'b0;
            #1;
            chk("tm_rst_intr", {15'd0, intr}, 16'd0);
            expect_reg("tm_rst_mask", 2'd0, 8'h00);
            expect_reg("tm_rst_timer", 2'd3, 8'h00);
            @(posedge clock);
            #1;
            reset_n = 1'b1;
            model_reset();
            model_on = 1'b1;
        end
`endif

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            irq  = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            ack  = intr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            we   = ($urandom_range(0, 5) == 0);
            data_w = 8'($urandom);
            if (we) address = BASE + 16'($urandom_range(0, 2));
            else if ($urandom_range(0, 3) == 0) address = 16'($urandom);
            else address = BASE + 16'($urandom_range(0, 4)) - 16'd0;
            tick();
        end
        we  = 1'b0;
        ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
